// File: rtl/morse_player.sv
// ============================================================================
//  Module      : morse_player
//  Description : Plays one 5-symbol Morse character (dot/dash, MSB first) as a
//                timed tone envelope; optional square-wave buzzer drive is
//                built only when MORSE_PLAYER_BUZZER_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_player #(
    parameter int UNIT_CYCLES      = 25_000_000,
    parameter int BUZZ_HALF_PERIOD = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] morse_code,
    output logic       tone_out,
    output logic       buzzer,
    output logic       busy,
    output logic       done,
    output logic [2:0] sym_idx
);

    localparam int              c_cnt_w     = $clog2(3*UNIT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_one_load   = c_cnt_w'(UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_three_load = c_cnt_w'(3*UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [4:0]      c_code_none = 5'b10101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MARK     = 2'd1,
        SPACE    = 2'd2,
        CHAR_GAP = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_next_cnt;
    logic [2:0]           r_sym;
    logic [2:0]           w_next_sym;
    // Shift register: bit 4 always holds the symbol currently playing
    logic [4:0]           r_code;
    logic [4:0]           w_next_code;
    logic                 w_done;
    logic                 r_tone;
    logic                 r_busy;
    logic                 r_done;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_sym   = r_sym;
        w_next_code  = r_code;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (morse_code != c_code_none)) begin
                    w_next_state = MARK;
                    w_next_code  = morse_code;
                    w_next_sym   = 3'd0;
                    w_next_cnt   = morse_code[4] ? c_three_load : c_one_load;
                end
            end
            MARK: begin
                if (r_cnt == '0) begin
                    if (r_sym == 3'd4) begin
                        w_next_state = CHAR_GAP;
                        w_next_cnt   = c_three_load;
                    end else begin
                        w_next_state = SPACE;
                        w_next_cnt   = c_one_load;
                    end
                end else begin
                    w_next_cnt = r_cnt - c_cnt_one;
                end
            end
            SPACE: begin
                if (r_cnt == '0) begin
                    w_next_state = MARK;
                    w_next_sym   = r_sym + 3'd1;
                    w_next_code  = {r_code[3:0], 1'b0};
                    w_next_cnt   = r_code[3] ? c_three_load : c_one_load;
                end else begin
                    w_next_cnt = r_cnt - c_cnt_one;
                end
            end
            CHAR_GAP: begin
                if (r_cnt == '0) begin
                    w_next_state = IDLE;
                    w_next_sym   = 3'd0;
                    w_next_cnt   = '0;
                    w_done       = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_sym   = 3'd0;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so they align with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sym   <= 3'd0;
            r_code  <= c_code_none;
            r_tone  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_sym   <= w_next_sym;
            r_code  <= w_next_code;
            r_tone  <= (w_next_state == MARK);
            r_busy  <= (w_next_state != IDLE);
            r_done  <= w_done;
        end
    end

    assign tone_out = r_tone;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sym_idx  = r_sym;

`ifdef MORSE_PLAYER_BUZZER_EN
    localparam int               c_bz_w    = $clog2(BUZZ_HALF_PERIOD + 1);
    localparam logic [c_bz_w-1:0] c_bz_load = c_bz_w'(BUZZ_HALF_PERIOD - 1);
    localparam logic [c_bz_w-1:0] c_bz_one  = c_bz_w'(1);

    logic [c_bz_w-1:0] r_bz_cnt;
    logic              r_buzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bz_cnt <= '0;
            r_buzz   <= 1'b0;
        end else if (w_next_state == MARK) begin
            if (r_state != MARK) begin
                r_buzz   <= 1'b1;
                r_bz_cnt <= c_bz_load;
            end else if (r_bz_cnt == '0) begin
                r_buzz   <= ~r_buzz;
                r_bz_cnt <= c_bz_load;
            end else begin
                r_bz_cnt <= r_bz_cnt - c_bz_one;
            end
        end else begin
            r_bz_cnt <= '0;
            r_buzz   <= 1'b0;
        end
    end

    assign buzzer = r_buzz;
`else
    // Always 0; the term only keeps BUZZ_HALF_PERIOD referenced in this build
    assign buzzer = 1'b0 & (BUZZ_HALF_PERIOD == 0);
`endif

endmodule

`default_nettype wire
